// File: rtl/scale_frame_sequencer_pkg.sv
// Shared types and helpers for the BRAM-fed scaling frame sequencer:
// FSM states, conversion type codes and the per-type output pixel budget.
package scale_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} seq_state_e;

  localparam int PIX_W = 20;

  localparam logic [2:0] CT_BYPASS = 3'd0;
  localparam logic [2:0] CT_DOWN2  = 3'd1;
  localparam logic [2:0] CT_DOWN4  = 3'd2;
  localparam logic [2:0] CT_UP2    = 3'd3;

  // Output pixels the scaler emits for one source frame of n words.
  function automatic logic [PIX_W-1:0] expected_pixels(input logic [2:0] ctype,
                                                       input int unsigned n);
    logic [PIX_W-1:0] e;
    case (ctype)
      CT_DOWN2: e = PIX_W'(n / 4);
      CT_DOWN4: e = PIX_W'(n / 16);
      CT_UP2:   e = PIX_W'(n * 4);
      default:  e = PIX_W'(n);
    endcase
    return e;
  endfunction

  function automatic logic type_valid(input logic [2:0] ctype);
    return (ctype <= CT_UP2);
  endfunction

endpackage

// File: rtl/scale_frame_sequencer_if.sv
// Control, scaler and BRAM-side signals of the frame sequencer; the slave
// modport is the sequencer, the master modport is whoever drives it.
interface scale_frame_sequencer_if #(
  parameter int ADDR_W = 16
) ();
  import scale_seq_pkg::*;

  logic              start;
  logic              continuous;
  logic              abort;
  logic [2:0]        convert_type_in;
  logic              scl_write_en;
  logic              scl_stop;
  logic              scl_clr_n;
  logic [2:0]        convert_type;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic              frame_start;
  logic              frame_done;
  logic              busy;
  logic [PIX_W-1:0]  pix_count;
  logic              err_stall;
  logic              err_cfg;

  modport master (
    output start, continuous, abort, convert_type_in, scl_write_en, scl_stop,
    input  scl_clr_n, convert_type, bram_addr, bram_en, frame_start,
           frame_done, busy, pix_count, err_stall, err_cfg
  );

  modport slave (
    input  start, continuous, abort, convert_type_in, scl_write_en, scl_stop,
    output scl_clr_n, convert_type, bram_addr, bram_en, frame_start,
           frame_done, busy, pix_count, err_stall, err_cfg
  );

endinterface

// File: rtl/scale_frame_sequencer_cycle_timer.sv
// Loadable down-counter; expire_o marks the enabled cycle that consumes
// the last count, so a load of N expires on the Nth enabled cycle.
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire_o = en_i && !load_i && (count_q == W'(1));

endmodule

// File: rtl/scale_frame_sequencer.sv
// Frame sequencer for the BRAM -> scaler -> LCD path: one frame per start,
// with stall-aware address generation, output counting and a blanking gap.
module scale_frame_sequencer
  import scale_seq_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int FRAME_WORDS   = 19200,
  parameter int GAP_CYCLES    = 64,
  parameter int STALL_TIMEOUT = 1024
) (
  input logic                     clk,
  input logic                     rst_n,
  scale_frame_sequencer_if.slave  bus
);

  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  seq_state_e        state_q;
  logic              clr_n_q;
  logic [2:0]        ctype_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bram_en_q;
  logic              frame_start_q;
  logic              frame_done_q;
  logic [PIX_W-1:0]  pix_q;
  logic [PIX_W-1:0]  expected_q;
  logic              err_stall_q;
  logic              err_cfg_q;
  logic              pending_q;

  logic stall_load, stall_en, stall_expire;
  logic gap_load, gap_en, gap_expire;
  logic pix_done, launch;

  // Stall timer rearms on every scaler write and whenever we are not in RUN.
  assign stall_load = (state_q != RUN) || bus.scl_write_en;
  assign stall_en   = (state_q == RUN);
  assign gap_load   = (state_q != GAP);
  assign gap_en     = (state_q == GAP);

  cycle_timer #(.W(STALL_W)) u_stall_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (stall_load),
    .load_val_i (STALL_W'(STALL_TIMEOUT)),
    .en_i       (stall_en),
    .expire_o   (stall_expire)
  );

  cycle_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (gap_load),
    .load_val_i (GAP_W'(GAP_CYCLES)),
    .en_i       (gap_en),
    .expire_o   (gap_expire)
  );

  assign pix_done = bus.scl_write_en && ((pix_q + PIX_W'(1)) == expected_q);
  assign launch   = ((state_q == IDLE) && bus.start) ||
                    ((state_q == GAP) && gap_expire &&
                     (bus.continuous || pending_q || bus.start));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      clr_n_q       <= 1'b0;
      ctype_q       <= '0;
      addr_q        <= '0;
      bram_en_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      pix_q         <= '0;
      expected_q    <= '0;
      err_stall_q   <= 1'b0;
      err_cfg_q     <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (bus.abort) begin
        state_q   <= IDLE;
        bram_en_q <= 1'b0;
        clr_n_q   <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        if (bus.start && state_q != IDLE) pending_q <= 1'b1;
        case (state_q)
          IDLE: ;
          LOAD: begin
            ctype_q       <= bus.convert_type_in;
            expected_q    <= expected_pixels(bus.convert_type_in, FRAME_WORDS);
            state_q       <= RUN;
            bram_en_q     <= 1'b1;
            clr_n_q       <= 1'b1;
            frame_start_q <= 1'b1;
          end
          RUN: begin
            if (!bus.scl_stop && addr_q < LAST_ADDR) addr_q <= addr_q + ADDR_W'(1);
            if (bus.scl_write_en) pix_q <= pix_q + PIX_W'(1);
            if (stall_expire) err_stall_q <= 1'b1;
            if (pix_done || stall_expire) begin
              state_q      <= GAP;
              bram_en_q    <= 1'b0;
              clr_n_q      <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
          GAP: begin
            if (gap_expire) begin
              state_q   <= IDLE;
              pending_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
        // A launch that finds a reserved type is refused and only flags it.
        if (launch) begin
          if (type_valid(bus.convert_type_in)) begin
            state_q     <= LOAD;
            addr_q      <= '0;
            pix_q       <= '0;
            clr_n_q     <= 1'b0;
            err_stall_q <= 1'b0;
            err_cfg_q   <= 1'b0;
            pending_q   <= 1'b0;
          end else begin
            err_cfg_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.scl_clr_n    = clr_n_q;
  assign bus.convert_type = ctype_q;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_en      = bram_en_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.pix_count    = pix_q;
  assign bus.err_stall    = err_stall_q;
  assign bus.err_cfg      = err_cfg_q;

endmodule

// File: doc/scale_frame_sequencer.md
Name: scale_frame_sequencer

Overview:
- Frame-level controller for the BRAM-fed scaling path: the BRAM source, the down/up-scaler, and the 16-bit RGB LCD write stream.
- Sequences one frame per start: latches conversion type, clears the scaler, drives the BRAM read address with stall support, counts output pixels to detect frame end, detects stalls, and inserts an inter-frame blanking gap.
- Replaces the free-running address counter; owns BRAM address generation and scaler configuration.

Parameters:
- ADDR_W, 16, BRAM address width.
- FRAME_WORDS, 19200, source words per frame (160x120); last address = FRAME_WORDS-1.
- GAP_CYCLES, 64, blanking cycles between frames, minimum 1.
- STALL_TIMEOUT, 1024, max cycles in RUN without scl_write_en before aborting with error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  request one frame, single-cycle pulse.
- continuous  in  1  1 = re-launch automatically after each gap.
- abort  in  1  synchronous abort to IDLE.
- convert_type_in  in  3  requested conversion: 0 bypass, 1 down2, 2 down4, 3 up2, 4-7 reserved.
- scl_write_en  in  1  scaler produced one RGB pixel this cycle.
- scl_stop  in  1  scaler back-pressure: hold the BRAM address.
- scl_clr_n  out  1  synchronous clear to scaler, active-low.
- convert_type  out  3  latched type to scaler.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_en  out  1  BRAM read enable.
- frame_start  out  1  one-cycle pulse on entry to RUN.
- frame_done  out  1  one-cycle pulse on entry to GAP.
- busy  out  1  state != IDLE.
- pix_count  out  20  output pixels counted in the current frame.
- err_stall  out  1  sticky: frame ended by timeout; cleared by the next LOAD.
- err_cfg  out  1  sticky: start seen with a reserved type; cleared by the next accepted start.

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. Reset values:
  - state = IDLE, scl_clr_n = 0, convert_type = 0, bram_addr = 0, bram_en = 0.
  - All pulses, pix_count and both error flags = 0.
- Expected output count E(type), from the package, fixed at LOAD:
  - bypass: N. down2: N/4. down4: N/16. up2: 4N. (N = FRAME_WORDS.)
- IDLE:
  - scl_clr_n = 0.
  - start with a valid type: go to LOAD next cycle.
  - start with a reserved type: err_cfg = 1, stay in IDLE.
- LOAD (exactly 1 cycle):
  - Latch convert_type_in; bram_addr = 0; pix_count = 0; err_stall = 0; scl_clr_n = 0.
  - Go to RUN.
- RUN:
  - scl_clr_n = 1, bram_en = 1; frame_start pulses in the first RUN cycle.
  - If scl_stop = 0 and bram_addr < FRAME_WORDS-1: bram_addr increments next cycle. Otherwise it holds. The address never wraps.
  - Each scl_write_en increments pix_count.
  - Exit when pix_count reaches E, counting the current-cycle write: go to GAP next cycle.
  - Stall counter resets on each scl_write_en. If it reaches STALL_TIMEOUT: err_stall = 1, go to GAP.
  - scl_write_en arriving after E is ignored (pix_count stays at E).
- GAP:
  - bram_en = 0, scl_clr_n = 0; frame_done pulses on the first cycle.
  - Count GAP_CYCLES cycles, then:
    - go to LOAD if continuous = 1 or a start is pending (valid type checked at that point);
    - otherwise go to IDLE.
- Start pending: a start during LOAD, RUN or GAP sets a one-deep pending flag. Further starts are dropped. The flag clears on LOAD.
- abort: highest priority, from any state.
  - Next cycle: IDLE, bram_en = 0, scl_clr_n = 0, pending cleared. No frame_done.
  - abort and start in the same cycle: abort wins and start is dropped.
- Latency: start → LOAD at +1 → first RUN cycle (bram_en = 1, addr 0) at +2. BRAM data is valid one cycle after bram_addr.
- Changes to convert_type_in outside LOAD have no effect on the frame in progress.

Decomposition:
- Package scale_seq_pkg holds:
  - state enum {IDLE, LOAD, RUN, GAP};
  - conversion type codes;
  - function expected_pixels(type, N) returning 20 bits;
  - function type_valid(type).
- One sub-module, cycle_timer: loadable down-counter with expire flag, instantiated twice (GAP length and stall timeout).

Test Plan:
- Bypass frame: type 0, start, scaler returns write_en every cycle, FRAME_WORDS = 16 → frame_start at cycle +2; bram_addr runs 0..15; frame_done after 16 pixels; pix_count = 16; IDLE after GAP_CYCLES.
- Back-pressure: scl_stop high for 5 cycles at addr 7 → bram_addr holds 7 for exactly 5 cycles, then resumes at 8; no error.
- Up2 with FRAME_WORDS = 16 → bram_addr saturates at 15; RUN continues until pix_count = 64; then frame_done.
- Stall: STALL_TIMEOUT = 8, scaler silent after 3 pixels → err_stall = 1 on the 8th idle cycle, GAP entered; next start clears err_stall.
- Continuous mode with type changed mid-frame from 0 to 1 → the current frame finishes with E = 16; the next LOAD latches 1, giving E = 4.
- Reserved type 5 start → err_cfg = 1, busy stays 0. Separately, abort mid-RUN → IDLE next cycle, bram_en = 0, no frame_done. Separately, async reset mid-RUN → all outputs at reset values immediately.
